mips_avalon_slave_mem: RTL and testbench
========================================

Name: mips_avalon_slave_mem

Overview:
Avalon-MM slave (responder) memory model: the far end of the CPU bus master in the `mips_cpu_bus` integration.
- Serves word reads and byte-enabled writes from a single word-addressed RAM mapped at BASE_ADDR.
- Inserts a configurable number of waitrequest stall cycles per transfer.
- Returns readdata registered, valid the cycle after acceptance.
- Used as instruction/data memory in CPU testbenches and as a synthesizable bus target.

Parameters:
- BASE_ADDR, 32'hBFC00000: byte address of word 0.
- DEPTH, 1024: number of 32-bit words; power of two, at least 4.
- WAIT_CYCLES, 1: waitrequest-high cycles per transfer; 0 to 15.
- LFSR_SEED, 8'hA5: nonzero seed, used only with RANDOM_WAIT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- address  input  32  byte address from master; bits [1:0] ignored.
- read  input  1  read request.
- write  input  1  write request.
- byteenable  input  4  write lane enables; bit i maps to writedata[8i+7:8i].
- writedata  input  32  write data.
- waitrequest  output  1  stall; the transfer is accepted in a cycle where (read|write) && !waitrequest.
- readdata  output  32  read data, registered.
- err  output  1  sticky protocol/range error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to S_IDLE, stall counter 0, readdata 32'h0, err 0, LFSR to LFSR_SEED.
  - waitrequest forced 1 while reset is low.
  - RAM contents are not cleared.
- Address decode:
  - offset = address - BASE_ADDR (32-bit, wraps).
  - in_range = offset[31:2] < DEPTH.
  - word index = offset[$clog2(DEPTH)+1:2].
- FSM states S_IDLE and S_STALL.
  - req = read | write.
  - S_IDLE, req=0: waitrequest 0, stay.
  - S_IDLE, req=1, WAIT_CYCLES=0: waitrequest 0, transfer accepted this cycle, stay in S_IDLE.
  - S_IDLE, req=1, WAIT_CYCLES>0: waitrequest 1, cnt <= WAIT_CYCLES-1, go to S_STALL.
  - S_STALL: waitrequest = (cnt != 0). If cnt != 0, decrement. If cnt == 0, accept and return to S_IDLE.
  - S_STALL with req dropped by master (violation): return to S_IDLE, no memory effect, set err.
- Timing: request first seen at cycle 0 gives waitrequest high in cycles 0..W-1, acceptance in cycle W, readdata valid from cycle W+1.
- Back-to-back transfers each incur the full W stalls.
- Accepted write:
  - RAM[index] lanes with byteenable=1 are updated at the accepting edge; other lanes are kept.
  - byteenable=0000 makes no change.
  - readdata is unchanged.
- Accepted read:
  - readdata <= RAM[index] (full word, byteenable ignored).
  - readdata holds until the next accepted read.
- read and write both high: treated as a read; no memory write; set err.
- Out-of-range access:
  - Read returns 32'h0; write is dropped; set err.
  - Still takes W stall cycles.
- err clears only on reset.
- Read of a just-written address on the next transfer returns the new data (no bypass hazard, since writes commit at acceptance).

Optional Feature:
- Macro: MIPS_AVALON_SLAVE_RANDOM_WAIT_EN.
- Defined:
  - Per-transfer stall count = WAIT_CYCLES + (lfsr[1:0]), from an 8-bit Fibonacci LFSR (taps 8,6,5,4).
  - The LFSR advances once per accepted transfer.
  - The sequence is deterministic from LFSR_SEED.
- Undefined: stall count is exactly WAIT_CYCLES and no LFSR logic is generated.

Decomposition:
- Package mips_avalon_pkg holds:
  - typedef typeSlaveState {S_IDLE, S_STALL};
  - localparams WORD_BYTES=4 and RESET_VECTOR=32'hBFC00000;
  - function byte_merge(old, new, be) returning the lane-merged word.
- Sub-module mips_avalon_lfsr8 (enable, seed, out), instantiated only under the macro.

Test Plan:
- Reset released, WAIT_CYCLES=0: write 32'hDEADBEEF to 0xBFC00000 with be=1111, then read it -> waitrequest never high; readdata=32'hDEADBEEF one cycle after read acceptance.
- WAIT_CYCLES=3: read 0xBFC00004 -> waitrequest high exactly 3 cycles; readdata valid on cycle 4; a back-to-back second read also stalls 3 cycles.
- Word holds 32'h11223344; write 32'hAABBCCDD with be=0101 -> read returns 32'h11BB33DD.
- Read 0x00000000 (out of range) -> readdata=32'h0, err=1; subsequent in-range read works and err stays 1.
- read=write=1 at 0xBFC00008 holding 32'h5 with writedata 32'h9 -> readdata=32'h5, memory unchanged, err=1.
- reset pulsed low during S_STALL -> waitrequest=1 and readdata=0 immediately; after release, a fresh transfer completes with full W stalls and RAM contents are preserved.

Source files
------------

// File: rtl/mips_avalon_pkg.sv
// Shared types and helpers for the Avalon-MM slave memory model.
// Holds the slave FSM state type, bus word constants and the byte-lane merge used on writes.
package mips_avalon_pkg;

   typedef enum logic {
      S_IDLE,
      S_STALL
   } typeSlaveState;

   localparam int          WORD_BYTES   = 4;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   // Combine a stored word with new write data, taking only the lanes whose byte enable is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = oldWord;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = newWord[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/mips_avalon_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that randomises the per-transfer stall count.
// Loads the seed on reset and steps once for every enable pulse.
module mips_avalon_lfsr8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] seed,
   output logic [7:0] out
);

   logic feedback;

   assign feedback = out[7] ^ out[5] ^ out[4] ^ out[3];

   // Shift register: reload the seed on reset, advance one step per accepted transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out <= seed;
      end else if (enable) begin
         out <= {out[6:0], feedback};
      end
   end

endmodule

// File: rtl/mips_avalon_slave_mem.sv
// Avalon-MM slave memory: word-addressed RAM at BASE_ADDR with waitrequest stalls,
// registered readdata and a sticky error flag for range and protocol violations.
// Optional macro MIPS_AVALON_SLAVE_RANDOM_WAIT_EN adds 0..3 LFSR-driven extra stalls per transfer.
module mips_avalon_slave_mem
   import mips_avalon_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int          DEPTH       = 1024,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        err
);

   localparam int          AW          = $clog2(DEPTH);
   localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);

   typeSlaveState state;
   typeSlaveState stateNext;
   logic [4:0]    cnt;
   logic [4:0]    cntNext;
   logic [4:0]    stallTotal;
   logic          req;
   logic          accept;
   logic          protoErr;
   logic          borrow;
   logic [29:0]   offsetWord;
   logic          inRange;
   logic [AW-1:0] wordIndex;
   logic [31:0]   mem [DEPTH];

   assign req = read | write;

   // Word offset from the base, computed on the upper address bits with the borrow from the
   // low bits so it equals (address - BASE_ADDR) >> 2 even for an unaligned base.
   assign borrow     = address[1:0] < BASE_ADDR[1:0];
   assign offsetWord = address[31:2] - BASE_ADDR[31:2] - {29'd0, borrow};
   assign inRange    = offsetWord < DEPTH_WORDS;
   assign wordIndex  = offsetWord[AW-1:0];

`ifdef MIPS_AVALON_SLAVE_RANDOM_WAIT_EN
   logic [7:0] lfsrOut;

   mips_avalon_lfsr8 uLfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (accept),
      .seed   (LFSR_SEED),
      .out    (lfsrOut)
   );

   assign stallTotal = 5'(WAIT_CYCLES) + {3'b000, lfsrOut[1:0]};
`else
   assign stallTotal = 5'(WAIT_CYCLES);
`endif

   // Handshake FSM: decides waitrequest, acceptance and the stall countdown for the current request.
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      waitrequest = 1'b0;
      accept      = 1'b0;
      protoErr    = 1'b0;
      if (!reset) begin
         waitrequest = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (stallTotal == 5'd0) begin
                     accept = 1'b1;
                  end else begin
                     waitrequest = 1'b1;
                     cntNext     = stallTotal - 5'd1;
                     stateNext   = S_STALL;
                  end
               end
            end
            S_STALL: begin
               waitrequest = (cnt != 5'd0);
               if (!req) begin
                  protoErr  = 1'b1;
                  cntNext   = 5'd0;
                  stateNext = S_IDLE;
               end else if (cnt != 5'd0) begin
                  cntNext = cnt - 5'd1;
               end else begin
                  accept    = 1'b1;
                  stateNext = S_IDLE;
               end
            end
            default: begin
               stateNext = S_IDLE;
               cntNext   = 5'd0;
            end
         endcase
      end
   end

   // State and stall counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= 5'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Registered read data and sticky error; a simultaneous read+write is served as a read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         readdata <= 32'h0;
         err      <= 1'b0;
      end else begin
         if (accept && read) begin
            readdata <= inRange ? mem[wordIndex] : 32'h0;
         end
         if (protoErr || (accept && (!inRange || (read && write)))) begin
            err <= 1'b1;
         end
      end
   end

   // RAM write port: lane-merged commit at the accepting edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && write && !read && inRange) begin
         mem[wordIndex] <= byte_merge(mem[wordIndex], writedata, byteenable);
      end
   end

endmodule

// File: tb/tb_mips_avalon_slave_mem.sv
// Self-checking bench for mips_avalon_slave_mem: a master task issues transfers and pushes
// expected read data from an array model; a monitor pops and compares whenever read data lands.
`timescale 1ns/1ps
module tb_mips_avalon_slave_mem;

   localparam logic [31:0] BASE  = 32'hBFC00000;
   localparam int          DEPTH = 16;
   localparam int          W     = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address = 32'h0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  byteenable = 4'h0;
   logic [31:0] writedata = 32'h0;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        err;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] model [DEPTH];
   logic        modelErr = 1'b0;
   logic [31:0] expQ [$];
   logic [31:0] expHold = 32'h0;
   logic        readPending = 1'b0;

   mips_avalon_slave_mem #(
      .BASE_ADDR   (BASE),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (W),
      .LFSR_SEED   (8'hA5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .read        (read),
      .write       (write),
      .byteenable  (byteenable),
      .writedata   (writedata),
      .waitrequest (waitrequest),
      .readdata    (readdata),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
      end
   endtask

   // Issue one transfer, count stalls, update the model and queue the expected read data.
   task automatic applyStimulus(input logic [31:0] a, input logic r, input logic w,
                                input logic [3:0] be, input logic [31:0] wd);
      int          stalls;
      logic [31:0] offs;
      logic [31:0] ix;
      logic        inR;
      stalls = 0;
      @(negedge clk);
      address = a; read = r; write = w; byteenable = be; writedata = wd;
      #1;
      while (waitrequest === 1'b1 && stalls < 50) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (stalls >= 50) begin
         checks++;
         failures++;
         $display("[TB] FAIL acceptTimeout: waitrequest still %b after %0d cycles, expected 0", waitrequest, stalls);
         read = 1'b0; write = 1'b0;
         return;
      end
`ifdef MIPS_AVALON_SLAVE_RANDOM_WAIT_EN
      checkOutput("stallCountInRange", 32'(stalls >= W && stalls <= W + 3), 32'd1);
`else
      checkOutput("stallCount", 32'(stalls), 32'(W));
`endif
      offs = a - BASE;
      ix   = offs >> 2;
      inR  = ix < DEPTH;
      if (r) begin
         expQ.push_back(inR ? model[ix] : 32'h0);
         if (w || !inR) modelErr = 1'b1;
      end else if (w) begin
         if (inR) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) model[ix][8*i +: 8] = wd[8*i +: 8];
            end
         end else begin
            modelErr = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("errAfterTransfer", {31'd0, err}, {31'd0, modelErr});
      read = 1'b0; write = 1'b0;
   endtask

   // Pulse reset while idle; model error and pending reads are cleared with it.
   task automatic doReset();
      @(negedge clk);
      reset = 1'b0;
      modelErr = 1'b0;
      expQ.delete();
      @(negedge clk);
      #1;
      checkOutput("errInReset", {31'd0, err}, 32'd0);
      reset = 1'b1;
   endtask

   // Start a write, then drop it during the stall: no memory effect, error must set.
   task automatic dropDuringStall(input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      address = a; read = 1'b0; write = 1'b1; byteenable = 4'hF; writedata = wd;
      #1;
      @(negedge clk);
      #1;
      write = 1'b0;
      modelErr = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("errViolation", {31'd0, err}, 32'd1);
   endtask

   // Monitor: readdata must hold its last value, and change exactly one cycle after a read is accepted.
   always @(negedge clk) begin
      #2;
      if (!reset) begin
         readPending = 1'b0;
         expHold = 32'h0;
      end else if (readPending) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedRead: readdata %h with empty queue, expected no read", readdata);
         end else begin
            expHold = expQ.pop_front();
         end
      end
      checkOutput("readdata", readdata, expHold);
      readPending = reset && read && !waitrequest;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time %0t, expected end before 200000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1;
      reset = 1'b0;
      #1;
      checkOutput("resetWaitrequest", {31'd0, waitrequest}, 32'd1);
      checkOutput("resetReaddata", readdata, 32'h0);
      checkOutput("resetErr", {31'd0, err}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(BASE + 32'(4 * i), 1'b0, 1'b1, 4'hF, $urandom);
      end

      applyStimulus(BASE, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
      applyStimulus(BASE, 1'b1, 1'b0, 4'h0, 32'h0);
      applyStimulus(BASE + 32'd4, 1'b1, 1'b0, 4'hF, 32'h0);
      applyStimulus(BASE + 32'd4, 1'b1, 1'b0, 4'hF, 32'h0);

      applyStimulus(BASE + 32'd20, 1'b0, 1'b1, 4'hF, 32'h11223344);
      applyStimulus(BASE + 32'd20, 1'b0, 1'b1, 4'b0101, 32'hAABBCCDD);
      applyStimulus(BASE + 32'd20, 1'b1, 1'b0, 4'h0, 32'h0);
      applyStimulus(BASE + 32'd20, 1'b0, 1'b1, 4'b0000, 32'h55555555);
      applyStimulus(BASE + 32'd20, 1'b1, 1'b0, 4'h0, 32'h0);

      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) applyStimulus(a, 1'b1, 1'b0, 4'($urandom), 32'h0);
         else                           applyStimulus(a, 1'b0, 1'b1, 4'($urandom), $urandom);
      end

      applyStimulus(BASE + 32'd12, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D);
      applyStimulus(BASE + 32'd12, 1'b1, 1'b0, 4'h0, 32'h0);
      @(negedge clk);
      address = BASE + 32'd12; read = 1'b1;
      #1;
      checkOutput("stallStartWaitrequest", {31'd0, waitrequest}, 32'd1);
      @(negedge clk);
      #1;
      reset = 1'b0;
      modelErr = 1'b0;
      expQ.delete();
      #1;
      checkOutput("midStallResetWaitrequest", {31'd0, waitrequest}, 32'd1);
      checkOutput("midStallResetReaddata", readdata, 32'h0);
      read = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      applyStimulus(BASE + 32'd12, 1'b1, 1'b0, 4'h0, 32'h0);

      applyStimulus(BASE + 32'd8, 1'b0, 1'b1, 4'hF, 32'h5);
      applyStimulus(BASE + 32'd8, 1'b1, 1'b1, 4'hF, 32'h9);
      applyStimulus(BASE + 32'd8, 1'b1, 1'b0, 4'h0, 32'h0);

      doReset();
      dropDuringStall(BASE + 32'd24, 32'h0BADF00D);
      applyStimulus(BASE + 32'd24, 1'b1, 1'b0, 4'h0, 32'h0);

      doReset();
      applyStimulus(32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
      applyStimulus(BASE + 32'd28, 1'b1, 1'b0, 4'h0, 32'h0);
      applyStimulus(BASE + 32'(4 * DEPTH), 1'b0, 1'b1, 4'hF, 32'h12345678);
      applyStimulus(BASE, 1'b1, 1'b0, 4'h0, 32'h0);

      repeat (3) @(negedge clk);
      #3;
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
